// File: rtl/alu_arb_seq.sv
// Round-robin arbiter that feeds two requesters into one shared ALU and returns one response at a time.
// ALU_ACC_CHAIN_EN: when defined, use_acc=1 replaces the command's x operand with acc[15:0].
module alu_arb_seq #(
  parameter int ACC_W = 17
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a_valid,
  input  logic             b_valid,
  output logic             a_ready,
  output logic             b_ready,
  input  logic [2:0]       a_op,
  input  logic [2:0]       b_op,
  input  logic [15:0]      a_x,
  input  logic [15:0]      b_x,
  input  logic [15:0]      a_y,
  input  logic [15:0]      b_y,
  input  logic             a_use_acc,
  input  logic             b_use_acc,
  output logic [15:0]      alu_x,
  output logic [15:0]      alu_y,
  output logic [2:0]       alu_op,
  input  logic [ACC_W-1:0] alu_out,
  input  logic             alu_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [ACC_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             halted,
  input  logic             err_clr,
  output logic [ACC_W-1:0] acc,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP, HALT} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [15:0]      alu_x_q, alu_x_d, alu_y_q, alu_y_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic [ACC_W-1:0] rsp_data_q, rsp_data_d, acc_q, acc_d;
  logic [15:0]      op_count_q, op_count_d;
  logic             halted_q, halted_d;
  logic             gnt_b, grant_en, sel_use_acc;

`ifndef ALU_ACC_CHAIN_EN
  logic unused_use_acc;
  assign unused_use_acc = a_use_acc ^ b_use_acc;
`endif

  // The ALU operands are registered at acceptance, so they double as the latched payload.
  always_comb begin
    gnt_b    = b_valid && (!a_valid || !last_grant_q);
    grant_en = reset_n && (state_q == IDLE);
    a_ready  = grant_en && a_valid && !gnt_b;
    b_ready  = grant_en && gnt_b;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    acc_d        = acc_q;
    op_count_d   = op_count_q;
    halted_d     = halted_q;
    sel_use_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_ready || b_ready) begin
          last_grant_d = b_ready;
          rsp_id_d     = b_ready;
          alu_x_d      = b_ready ? b_x  : a_x;
          alu_y_d      = b_ready ? b_y  : a_y;
          alu_op_d     = b_ready ? b_op : a_op;
`ifdef ALU_ACC_CHAIN_EN
          sel_use_acc  = b_ready ? b_use_acc : a_use_acc;
`endif
          if (sel_use_acc) alu_x_d = acc_q[15:0];
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_err_d   = alu_err;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_err_q) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            acc_d      = rsp_data_q;
            op_count_d = op_count_q + 16'd1;
            state_d    = IDLE;
          end
        end
      end
      HALT: begin
        if (err_clr) begin
          halted_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      acc_q        <= '0;
      op_count_q   <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      acc_q        <= acc_d;
      op_count_q   <= op_count_d;
      halted_q     <= halted_d;
    end
  end

  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign acc       = acc_q;
  assign op_count  = op_count_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_alu_arb_seq.sv
// Directed bench for alu_arb_seq; the bench also plays the shared ALU (op 000 = add with carry error, else xor).
module tb_alu_arb_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid = 0, b_valid = 0, a_use_acc = 0, b_use_acc = 0;
  logic        a_ready, b_ready;
  logic [2:0]  a_op = 0, b_op = 0, alu_op;
  logic [15:0] a_x = 0, b_x = 0, a_y = 0, b_y = 0, alu_x, alu_y;
  logic [16:0] alu_out, rsp_data, acc;
  logic        alu_err, rsp_valid, rsp_ready = 0, rsp_id, rsp_err, halted, err_clr = 0;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clock = ~clock;

  alu_arb_seq dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
    .a_op(a_op), .b_op(b_op), .a_x(a_x), .b_x(b_x), .a_y(a_y), .b_y(b_y),
    .a_use_acc(a_use_acc), .b_use_acc(b_use_acc),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_out(alu_out), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .halted(halted), .err_clr(err_clr), .acc(acc), .op_count(op_count)
  );

  always_comb begin
    logic [16:0] s;
    s       = {1'b0, alu_x} + {1'b0, alu_y};
    alu_out = {1'b0, alu_x ^ alu_y};
    alu_err = 1'b0;
    if (alu_op == 3'b000) begin
      if (s[16]) begin
        alu_out = '0;
        alu_err = 1'b1;
      end else begin
        alu_out = s;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Present one command at a negedge, expect an immediate grant, drop valid after acceptance.
  task automatic send(input logic is_b, input logic [2:0] op, input logic [15:0] x, y, input logic ua);
    if (is_b) begin
      b_valid = 1; b_op = op; b_x = x; b_y = y; b_use_acc = ua;
    end else begin
      a_valid = 1; a_op = op; a_x = x; a_y = y; a_use_acc = ua;
    end
    #1;
    chk(is_b ? "b_ready" : "a_ready", is_b ? b_ready : a_ready, 1);
    @(posedge clock);
    @(negedge clock);
    if (is_b) b_valid = 0; else a_valid = 0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      cyc++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic ack();
    rsp_ready = 1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 0;
  endtask

  initial begin
    // Reset: requesters valid but nothing may be granted.
    a_valid = 1; b_valid = 1;
    @(negedge clock);
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    @(negedge clock);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_alu_x", alu_x, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // Tie from reset: A, B, A, B.
    a_op = 3'b001; a_x = 16'h0001; a_y = 16'h0002;
    b_op = 3'b001; b_x = 16'h0004; b_y = 16'h0008;
    reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(n);
      chk("rr_id", rsp_id, k % 2);
      chk("rr_data", rsp_data, (k % 2) ? 17'h0000C : 17'h00003);
      if (k == 3) begin
        a_valid = 0; b_valid = 0;
      end
      ack();
    end
    chk("rr_acc", acc, 17'h0000C);
    chk("rr_op_count", op_count, 4);

    // Single A add.
    do_reset();
    send(0, 3'b000, 16'h00E1, 16'h0B01, 0);
    chk("exec_a_ready", a_ready, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_alu_x", alu_x, 16'h00E1);
    chk("exec_alu_y", alu_y, 16'h0B01);
    wait_rsp(n);
    chk("latency", n, 1);
    chk("add_id", rsp_id, 0);
    chk("add_data", rsp_data, 17'h00BE2);
    chk("add_err", rsp_err, 0);
    ack();
    chk("add_rsp_valid", rsp_valid, 0);
    chk("add_acc", acc, 17'h00BE2);
    chk("add_op_count", op_count, 1);

    // B with use_acc, response stalled for 5 cycles while A waits.
    send(1, 3'b100, 16'h1234, 16'h00FF, 1);
`ifdef ALU_ACC_CHAIN_EN
    chk("chain_alu_x", alu_x, 16'h0BE2);
`else
    chk("chain_alu_x", alu_x, 16'h1234);
`endif
    wait_rsp(n);
    a_valid = 1; a_op = 3'b001; a_x = 16'h0009; a_y = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", rsp_valid, 1);
`ifdef ALU_ACC_CHAIN_EN
      chk("stall_rsp_data", rsp_data, 17'h00B1D);
`else
      chk("stall_rsp_data", rsp_data, 17'h012CB);
`endif
      chk("stall_a_ready", a_ready, 0);
      @(negedge clock);
    end
    a_valid = 0;
    ack();
`ifdef ALU_ACC_CHAIN_EN
    chk("chain_acc", acc, 17'h00B1D);
`else
    chk("chain_acc", acc, 17'h012CB);
`endif
    chk("chain_op_count", op_count, 2);

    // Overflow halts; err_clr resumes, round robin continues.
    send(0, 3'b000, 16'h0001, 16'hFFFF, 0);
    wait_rsp(n);
    chk("ovf_err", rsp_err, 1);
    chk("ovf_data", rsp_data, 0);
    ack();
    chk("ovf_halted", halted, 1);
`ifdef ALU_ACC_CHAIN_EN
    chk("ovf_acc", acc, 17'h00B1D);
`else
    chk("ovf_acc", acc, 17'h012CB);
`endif
    chk("ovf_op_count", op_count, 2);
    a_valid = 1; a_op = 3'b001; a_x = 16'h0009; a_y = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_a_ready", a_ready, 0);
      @(negedge clock);
    end
    err_clr = 1;
    @(posedge clock);
    @(negedge clock);
    err_clr = 0;
    chk("clr_halted", halted, 0);
    b_valid = 1; b_op = 3'b001; b_x = 16'h0005; b_y = 16'h0003; b_use_acc = 0;
    #1;
    chk("post_halt_b_ready", b_ready, 1);
    chk("post_halt_a_ready", a_ready, 0);
    @(posedge clock);
    @(negedge clock);
    a_valid = 0; b_valid = 0;
    wait_rsp(n);
    chk("post_halt_id", rsp_id, 1);
    chk("post_halt_data", rsp_data, 17'h00006);
    ack();
    chk("post_halt_acc", acc, 17'h00006);
    chk("post_halt_op_count", op_count, 3);

    // Reset while a response is pending.
    send(0, 3'b001, 16'h00F0, 16'h000F, 0);
    wait_rsp(n);
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    reset_n = 0;
    @(negedge clock);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_op_count", op_count, 0);
    reset_n = 1;
    @(negedge clock);
    chk("mid_rst_idle_rsp_valid", rsp_valid, 0);

    // op_count wrap.
    force dut.op_count_q = 16'hFFFF;
    @(posedge clock);
    @(negedge clock);
    release dut.op_count_q;
    send(0, 3'b001, 16'h0007, 16'h0001, 0);
    wait_rsp(n);
    ack();
    chk("wrap_op_count", op_count, 16'h0000);
    chk("wrap_acc", acc, 17'h00006);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
